multiplier_seq_shiftadd: RTL and testbench
==========================================

# multiplier_seq_shiftadd

- Parametrised, iterative shift-add multiplier; next generation after the fixed 4-bit combinational multipliers.
- Computes `product = A * B` for WIDTH-bit operands, retiring one multiplier bit per clock.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths and multiplier benchmarking benches where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands (IDLE only)
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  registered result
- busy  output  1  high in CALC or DONE

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch A into the multiplicand register and B into the multiplier shift register, clear the accumulator, set count=0, go to CALC.
- CALC (in_ready=0, busy=1), each edge:
  - If multiplier LSB=1, accumulator upper half += multiplicand (WIDTH+1-bit add, carry kept).
  - Shift {carry, accumulator, multiplier} right by 1.
  - count++.
  - When count reaches WIDTH-1 on that edge, go to DONE and register product.
- DONE:
  - out_valid=1; product is stable until the handshake.
  - On an edge with out_valid&out_ready, go to IDLE.
  - out_valid and product hold indefinitely while out_ready=0.
- in_valid is ignored outside IDLE; A and B may change freely once accepted.
- Arithmetic is unsigned by default. The result is exact for all inputs, e.g. (2^WIDTH-1)^2 fits in 2*WIDTH bits with no overflow.
- The counter is $clog2(WIDTH) bits wide, and WIDTH need not be a power of two.
- Reset, asynchronous and valid at any point including mid-CALC or DONE:
  - State goes to IDLE and the in-flight operation is discarded.
  - Outputs: in_ready=1, out_valid=0, busy=0, product=0.

## Timing
- Accept edge is T0. Bits are processed on edges T1..TWIDTH.
- out_valid is high in the cycle after edge TWIDTH, i.e. WIDTH cycles after the accept edge.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH compute edges, one DONE cycle with out_ready=1, then back in IDLE.
- in_ready falls in the cycle after the accept edge and rises in the cycle after the output handshake.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- product changes only on the edge that enters DONE, or on reset.

## Configuration
- Macro MULT_SIGNED_EN.
- Defined:
  - A and B are two's-complement; product is the signed 2*WIDTH-bit result.
  - The multiplicand is sign-extended into the WIDTH+1-bit adder.
  - On the final CALC step, where the multiplier bit is B's MSB, the multiplicand is subtracted instead of added.
  - Latency is unchanged.
- Undefined: pure unsigned behaviour as above.
- The port list is identical in both builds.

## Test plan
- WIDTH=4, unsigned, out_ready=1:
  - A=2, B=3 → product=6, out_valid exactly 4 cycles after the accept edge.
  - A=10, B=3 → 30.
  - A=13, B=10 → 130.
- WIDTH=4, unsigned corners:
  - A=15, B=15 → 225 (8'hE1).
  - A=0, B=9 → 0.
  - A=7, B=1 → 7.
- Backpressure, WIDTH=8:
  - A=200, B=150 with out_ready=0 for 10 cycles → out_valid and product=30000 held stable, in_ready=0 throughout.
  - out_ready=1 → IDLE the next cycle.
- Reset mid-CALC:
  - Assert rst 2 cycles after accepting A=5, B=5 → out_valid=0, product=0, in_ready=1 immediately (async).
  - A subsequent A=3, B=4 → 12 with normal latency.
- With MULT_SIGNED_EN, WIDTH=4:
  - A=4'b1101 (-3), B=4'b1010 (-6) → 8'h12 (18).
  - A=-8, B=7 → 8'hC8 (-56).
  - A=-8, B=-8 → 8'h40 (64).
- Back-to-back stream, WIDTH=8, in_valid held high with 16 random operand pairs → every product matches the reference model and initiation interval is 10 cycles.

Source files
------------

// File: rtl/multiplier_seq_shiftadd.sv
// Iterative shift-add multiplier: one multiplier bit is retired per clock, with valid/ready on both sides.
// Define MULT_SIGNED_EN for two's-complement operands; otherwise the build is unsigned.
module multiplier_seq_shiftadd #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     mplr_q;
   logic [CW-1:0]        count_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic                 last_d;
   logic [WIDTH:0]       sum_d;
   logic [WIDTH-1:0]     acc_d;
   logic [WIDTH-1:0]     mplr_d;

   // One shift-add step: conditional add into the upper half, then shift {carry, acc, mplr} right.
   always_comb begin
      last_d = (count_q == CW'(WIDTH - 1));
      sum_d  = '0;
      if (mplr_q[0]) begin
`ifdef MULT_SIGNED_EN
         // The MSB of B carries negative weight, so the final step subtracts.
         if (last_d) begin
            sum_d = {acc_q[WIDTH-1], acc_q} - {mcand_q[WIDTH-1], mcand_q};
         end else begin
            sum_d = {acc_q[WIDTH-1], acc_q} + {mcand_q[WIDTH-1], mcand_q};
         end
`else
         sum_d = {1'b0, acc_q} + {1'b0, mcand_q};
`endif
      end else begin
`ifdef MULT_SIGNED_EN
         sum_d = {acc_q[WIDTH-1], acc_q};
`else
         sum_d = {1'b0, acc_q};
`endif
      end
      acc_d  = sum_d[WIDTH:1];
      mplr_d = {sum_d[0], mplr_q[WIDTH-1:1]};
   end

   // Control FSM with registered handshake/status outputs and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplr_q      <= '0;
         count_q     <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  mcand_q    <= A;
                  mplr_q     <= B;
                  acc_q      <= '0;
                  count_q    <= '0;
                  state_q    <= S_CALC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q    <= S_IDLE;
               end
            end
            S_CALC: begin
               acc_q   <= acc_d;
               mplr_q  <= mplr_d;
               count_q <= count_q + CW'(1);
               if (last_d) begin
                  state_q     <= S_DONE;
                  product_q   <= {acc_d, mplr_d};
                  out_valid_q <= 1'b1;
               end else begin
                  state_q     <= S_CALC;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end else begin
                  state_q     <= S_DONE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule

// File: tb/tb_multiplier_seq_shiftadd.sv
// Self-checking bench for multiplier_seq_shiftadd: WIDTH=4 and WIDTH=8 instances against an arithmetic reference.
module tb_multiplier_seq_shiftadd;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       iv4, ir4, ov4, or4, busy4;
   logic [3:0] a4, b4;
   logic [7:0] p4;

   logic        iv8, ir8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int total = 0;
   int bad   = 0;

   multiplier_seq_shiftadd #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
      .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4));

   multiplier_seq_shiftadd #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
      .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8));

   // Reference: plain integer product of the operands interpreted per build, truncated to 2*w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] mask;
      mask = (64'd1 << (2 * w)) - 64'd1;
      sa = longint'(a);
      sb = longint'(b);
`ifdef MULT_SIGNED_EN
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
      return 64'(sa * sb) & mask;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b);
      int lat;
      @(negedge clk);
      a4 = a; b4 = b; iv4 = 1'b1;
      @(negedge clk);
      iv4 = 1'b0; a4 = ~a; b4 = ~b;
      check("w4_in_ready_low", 64'(ir4), 64'd0);
      check("w4_busy_high", 64'(busy4), 64'd1);
      lat = 0;
      while (!ov4 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("w4_latency", 64'(lat), 64'd4);
      check("w4_product", 64'(p4), ref_mul(4, 32'(a), 32'(b)));
      @(negedge clk);
      check("w4_out_valid_drop", 64'(ov4), 64'd0);
      check("w4_in_ready_back", 64'(ir4), 64'd1);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
      int lat;
      logic [63:0] exp;
      exp = ref_mul(8, 32'(a), 32'(b));
      or8 = (hold == 0);
      @(negedge clk);
      a8 = a; b8 = b; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!ov8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("w8_latency", 64'(lat), 64'd8);
      check("w8_product", 64'(p8), exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(ov8), 64'd1);
         check("bp_product", 64'(p8), exp);
         check("bp_in_ready", 64'(ir8), 64'd0);
      end
      or8 = 1'b1;
      @(negedge clk);
      check("w8_out_valid_drop", 64'(ov8), 64'd0);
      check("w8_in_ready_back", 64'(ir8), 64'd1);
      check("w8_busy_drop", 64'(busy8), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      iv4 = 1'b0; or4 = 1'b1; a4 = 4'd0; b4 = 4'd0;
      iv8 = 1'b0; or8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
      #12;
      check("rst_in_ready", 64'({ir4, ir8}), 64'd3);
      check("rst_out_valid", 64'({ov4, ov8}), 64'd0);
      check("rst_busy", 64'({busy4, busy8}), 64'd0);
      check("rst_product", 64'({p4, p8}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run4(4'd2, 4'd3);
      run4(4'd10, 4'd3);
      run4(4'd13, 4'd10);
      run4(4'd15, 4'd15);
      run4(4'd0, 4'd9);
      run4(4'd7, 4'd1);
      run4(4'b1101, 4'b1010);
      run4(4'b1000, 4'b0111);
      run4(4'b1000, 4'b1000);
      for (int i = 0; i < 4; i++) run4(4'($urandom), 4'($urandom));

      run8(8'd200, 8'd150, 10);

      // Reset two cycles into a computation must clear everything immediately.
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(ov8), 64'd0);
      check("mid_rst_product", 64'(p8), 64'd0);
      check("mid_rst_in_ready", 64'(ir8), 64'd1);
      check("mid_rst_busy", 64'(busy8), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run8(8'd3, 8'd4, 0);
      run8(8'hFF, 8'hFF, 0);

      begin : stream
         logic [63:0] exp_q[$];
         int sent;
         int got;
         int cyc;
         int last_ov;
         sent = 0; got = 0; cyc = 0; last_ov = -1;
         or8 = 1'b1;
         @(negedge clk);
         while (got < 16 && cyc < 400) begin
            if (ov8) begin
               check("stream_product", 64'(p8), exp_q.pop_front());
               if (last_ov >= 0) check("stream_ii", 64'(cyc - last_ov), 64'd10);
               last_ov = cyc;
               got++;
            end
            if (ir8) begin
               if (sent < 16) begin
                  a8 = 8'($urandom);
                  b8 = 8'($urandom);
                  exp_q.push_back(ref_mul(8, 32'(a8), 32'(b8)));
                  iv8 = 1'b1;
                  sent++;
               end else begin
                  iv8 = 1'b0;
               end
            end
            @(negedge clk);
            cyc++;
         end
         check("stream_count", 64'(got), 64'd16);
         iv8 = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
